// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Byte / halfword / word load-store engine placed between the
//             pipeline MEM stage and a word-only data_memory (combinational
//             read, write on clock edge). Sub-word stores are performed as a
//             read-merge-write; loads are sign- or zero-extended; misaligned
//             or illegal requests get an error response and never write.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req_*               - valid/ready request channel
//             resp_*              - one-cycle response pulse, data and error
//             mem_we/mem_a/mem_wd - write enable, address, write data to RAM
//             mem_rd              - combinational read data from RAM
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_READ  = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_RESP  = 3'd4;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;
    localparam logic [1:0] c_SZ_ILL  = 2'b11;

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [15:0] r_wdata;      // only the low half is ever merged into memory
    logic [31:0] r_wd;         // merged word or full store word; drives mem_wd
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge;

    assign req_ready  = (r_state == c_IDLE) && !rst;
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (r_state == c_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_a      = r_addr;
    assign mem_wd     = r_wd;
    // Combinational gating with rst guarantees an interrupted store never lands.
    assign mem_we     = (r_state == c_WRITE) && !rst;

    assign w_misaligned = (req_size == c_SZ_ILL) ||
                          ((req_size == c_SZ_HALF) && req_addr[0]) ||
                          ((req_size == c_SZ_WORD) && (req_addr[1:0] != 2'b00));

    // Lane extraction / extension for loads and lane replacement for
    // sub-word stores, both driven from the latched request.
    always_comb begin
        w_byte = 8'h00;
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rd[7:0];
            2'd1:    w_byte = mem_rd[15:8];
            2'd2:    w_byte = mem_rd[23:16];
            default: w_byte = mem_rd[31:24];
        endcase
        w_half = r_addr[1] ? mem_rd[31:16] : mem_rd[15:0];

        case (r_size)
            c_SZ_BYTE: w_load_data = r_unsigned ? {24'h0, w_byte}
                                                : {{24{w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load_data = r_unsigned ? {16'h0, w_half}
                                                : {{16{w_half[15]}}, w_half};
            default:   w_load_data = mem_rd;
        endcase

        w_merge = mem_rd;
        if (r_size == c_SZ_BYTE) begin
            case (r_addr[1:0])
                2'd0:    w_merge[7:0]   = r_wdata[7:0];
                2'd1:    w_merge[15:8]  = r_wdata[7:0];
                2'd2:    w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata;
        end else begin
            w_merge[15:0]  = r_wdata;
        end
    end

    // Response registers are only written on the way into RESP so they hold
    // their value between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_addr       <= 32'h0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_wdata      <= 16'h0;
            r_wd         <= 32'h0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= req_addr;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_wdata    <= req_wdata[15:0];
                        if (w_misaligned) begin
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0;
                            r_state      <= c_RESP;
                        end else if (!req_we) begin
                            r_state <= c_LOAD;
                        end else if (req_size == c_SZ_WORD) begin
                            r_wd    <= req_wdata;
                            r_state <= c_WRITE;
                        end else begin
                            r_state <= c_READ;
                        end
                    end
                end
                c_LOAD: begin
                    r_resp_rdata <= w_load_data;
                    r_resp_err   <= 1'b0;
                    r_state      <= c_RESP;
                end
                c_READ: begin
                    r_wd    <= w_merge;
                    r_state <= c_WRITE;
                end
                c_WRITE: begin
                    r_resp_rdata <= 32'h0;
                    r_resp_err   <= 1'b0;
                    r_state      <= c_RESP;
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sits between the pipeline MEM stage and `data_memory`, a 64-word, word-addressed RAM with combinational read and write on the clock edge. Accepts one load or store per valid/ready handshake and performs byte, halfword and word accesses on top of that word-only RAM. Sub-word stores use a read-merge-write sequence. Loads are sign- or zero-extended. Misaligned or illegal requests return an error response and never write memory.

## Interface
Parameters:
- none (word size fixed at 32, memory geometry owned by `data_memory`)

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `resp_valid`  out  1  one-cycle response pulse
- `resp_rdata`  out  32  load result; 0 for stores and errors
- `resp_err`  out  1  request was misaligned or illegal
- `mem_we`  out  1  to `data_memory.we`
- `mem_a`  out  32  to `data_memory.a`
- `mem_wd`  out  32  to `data_memory.wd`
- `mem_rd`  in  32  from `data_memory.rd`, combinational

## Operation
- Lanes are little-endian: byte lane k = bits [8k+7:8k], with k = addr[1:0]. The halfword lane is selected by addr[1].
- Alignment error when any of these holds:
  - size 11
  - half with addr[0]=1
  - word with addr[1:0]≠0
- Handshake: a request is accepted when `req_valid && req_ready`. All request fields are latched at acceptance. `req_ready` = (state==IDLE) && !`rst`.
- States:
  - IDLE
    - On accept with error → RESP, with err_q=1 and rdata_q=0.
    - On accept of a load → LOAD.
    - On accept of a word store → WRITE.
    - On accept of a byte or half store → READ.
  - LOAD
    - `mem_a`=addr_q.
    - Extract the selected lane of `mem_rd` and extend it per size/unsigned into rdata_q.
    - → RESP.
  - READ
    - `mem_a`=addr_q.
    - merge_q = `mem_rd` with the selected lane replaced by `req_wdata`[7:0] (byte) or [15:0] (half).
    - → WRITE.
  - WRITE
    - `mem_a`=addr_q, `mem_we`=1.
    - `mem_wd` = merge_q for sub-word stores, wdata_q for word stores.
    - → RESP.
  - RESP
    - `resp_valid`=1.
    - `resp_rdata`=rdata_q (0 for stores), `resp_err`=err_q.
    - → IDLE.
- `mem_we` is 1 only in WRITE and only while `rst`=0. Any request still in flight is dropped without a response.
- Outside LOAD/READ/WRITE, `mem_a` holds addr_q and `mem_wd` holds its last value.
- `resp_rdata` and `resp_err` hold their values until the next RESP. They are meaningful only while `resp_valid`=1.
- Address bits above [7:2] are passed through unchanged. Out-of-range addresses are not checked.

## Timing
- Reset values (after any edge with `rst`=1):
  - state IDLE
  - `resp_valid`, `resp_err`, `mem_we` = 0
  - `resp_rdata`, `mem_a`, `mem_wd` = 0
  - all latched request registers = 0
- Latency, counted from the accept edge to the cycle in which `resp_valid`=1:
  - error: 1 cycle
  - load and word store: 2 cycles
  - byte/half store: 3 cycles
- `req_ready` is low from the cycle after accept until the cycle after RESP. Back-to-back request spacing:
  - error: 2 cycles
  - load / word store: 3 cycles
  - sub-word store: 4 cycles
- Memory is updated on the rising edge that ends WRITE. A load accepted after a store's RESP observes the stored data.
- If `rst` is asserted while in READ or WRITE, no write occurs. The unit is in IDLE with `req_ready`=1 in the first cycle after `rst` deasserts.
- `req_valid` with `req_ready`=0 is ignored. The requester must hold the request until it is accepted.

## Test plan
- Word store then load:
  - Store 0xDEADBEEF to addr 0x10; response 2 cycles after accept with err=0.
  - Load word from 0x10 → `resp_rdata`=0xDEADBEEF.
- Sub-word load extension with word 0x80FF7F01 at 0x20:
  - byte signed @0x23 → 0xFFFFFF80
  - byte unsigned @0x21 → 0x0000007F
  - half signed @0x22 → 0xFFFF80FF
  - half unsigned @0x20 → 0x00007F01
- Sub-word store merge, starting from 0x11223344 at 0x30:
  - Store byte 0xAA @0x31 → word becomes 0x1122AA44.
  - Then store half 0xBEEF @0x32 → word becomes 0xBEEFAA44.
  - Each store has 3-cycle latency and `mem_we` high exactly one cycle.
- Alignment errors, each giving `resp_err`=1, `resp_rdata`=0, 1-cycle latency and `mem_we` never 1:
  - half @0x05
  - word @0x06
  - size 11 @0x00
- Reset mid-store:
  - Assert `rst` during the WRITE cycle of a byte store to 0x40 holding 0x00000000.
  - Memory stays 0; `resp_valid` stays 0; `req_ready`=1 the cycle after `rst` falls.
- Handshake stress:
  - Hold `req_valid`=1 continuously with alternating loads and stores.
  - Exactly one response per accepted request, in order.
  - No accept occurs while `req_ready`=0.
